// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-requester credit, rotating priority.
// Optional hold-on-lock behaviour is enabled with the WRR_LOCK_EN macro (adds the lock port).
module weighted_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WGT_W = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         request,
    input  logic [N*WGT_W-1:0]   weight,
`ifdef WRR_LOCK_EN
    input  logic [N-1:0]         lock,
`endif
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [WGT_W-1:0]   r_credit;
    logic [N-1:0]       r_grant;
    logic               r_grant_valid;
    logic [IDX_W-1:0]   r_grant_idx;

    state_t             w_state;
    logic [IDX_W-1:0]   w_ptr;
    logic [WGT_W-1:0]   w_credit;
    logic [N-1:0]       w_grant;
    logic               w_grant_valid;
    logic [IDX_W-1:0]   w_grant_idx;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_cand;
    logic [WGT_W-1:0]   w_wgt;
    logic [WGT_W-1:0]   w_wgt_eff;
    logic               w_hold_req;
    logic               w_locked;
    logic               w_arb;

    // Wrap-around priority scan starting at r_ptr
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = IDX_W'((32'(r_ptr) + k) % N);
            if (!w_found && request[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Weight of the winner; zero is treated as a single cycle
    always_comb begin
        w_wgt     = weight[32'(w_win)*WGT_W +: WGT_W];
        w_wgt_eff = (w_wgt == '0) ? WGT_W'(1) : w_wgt;
    end

    always_comb begin
        w_hold_req = request[r_grant_idx];
`ifdef WRR_LOCK_EN
        w_locked   = lock[r_grant_idx] & w_hold_req;
`else
        w_locked   = 1'b0;
`endif
        w_arb      = (r_state == S_IDLE) || !w_hold_req ||
                     ((r_credit == WGT_W'(1)) && !w_locked);
    end

    // Next-state and next-output logic
    always_comb begin
        w_state       = r_state;
        w_ptr         = r_ptr;
        w_credit      = r_credit;
        w_grant       = r_grant;
        w_grant_valid = r_grant_valid;
        w_grant_idx   = r_grant_idx;
        if (w_arb) begin
            if (w_found) begin
                w_state       = S_BUSY;
                w_grant       = {{(N-1){1'b0}}, 1'b1} << w_win;
                w_grant_valid = 1'b1;
                w_grant_idx   = w_win;
                w_credit      = w_wgt_eff;
                w_ptr         = (w_win == IDX_W'(N-1)) ? '0 : w_win + 1'b1;
            end else begin
                w_state       = S_IDLE;
                w_grant       = '0;
                w_grant_valid = 1'b0;
                w_credit      = '0;
            end
        end else if (r_credit > WGT_W'(1)) begin
            // Under lock the credit saturates at 1 rather than wrapping
            w_credit = r_credit - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_credit      <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
        end else begin
            r_state       <= w_state;
            r_ptr         <= w_ptr;
            r_credit      <= w_credit;
            r_grant       <= w_grant;
            r_grant_valid <= w_grant_valid;
            r_grant_idx   <= w_grant_idx;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed literal sequences plus randomized traffic
// checked every cycle against an integer-level arbitration model.
module tb_weighted_rr_arbiter;

    localparam int N     = 4;
    localparam int WGT_W = 4;
    localparam int IDX_W = 2;

    logic                 clk     = 1'b0;
    logic                 rst_n   = 1'b1;
    logic [N-1:0]         request = '0;
    logic [N*WGT_W-1:0]   weight  = '0;
`ifdef WRR_LOCK_EN
    logic [N-1:0]         lock    = '0;
`endif
    logic [N-1:0]         grant;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    weighted_rr_arbiter #(.N(N), .WGT_W(WGT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .weight      (weight),
`ifdef WRR_LOCK_EN
        .lock        (lock),
`endif
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always #5 clk = ~clk;

    // Model state: holder -1 means idle
    int m_holder = -1;
    int m_credit = 0;
    int m_ptr    = 0;
    int m_idx    = 0;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic int eff_wt(input int i);
        int w;
        w = int'(weight[i*WGT_W +: WGT_W]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit arb_now();
        bit lk;
        lk = 1'b0;
        if (m_holder < 0) return 1'b1;
        if (!request[m_holder]) return 1'b1;
`ifdef WRR_LOCK_EN
        lk = lock[m_holder];
`endif
        return (m_credit == 1) && !lk;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_holder <= -1;
            m_credit <= 0;
            m_ptr    <= 0;
            m_idx    <= 0;
        end else if (arb_now()) begin
            if (pick(request, m_ptr) >= 0) begin
                m_holder <= pick(request, m_ptr);
                m_idx    <= pick(request, m_ptr);
                m_credit <= eff_wt(pick(request, m_ptr));
                m_ptr    <= (pick(request, m_ptr) + 1) % N;
            end else begin
                m_holder <= -1;
            end
        end else begin
            m_credit <= (m_credit > 1) ? m_credit - 1 : 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_grant", int'(grant), (m_holder < 0) ? 0 : (1 << m_holder));
            cmp("model_valid", int'(grant_valid), (m_holder < 0) ? 0 : 1);
            cmp("model_idx",   int'(grant_idx), m_idx);
        end
    end

    task automatic expect_cyc(input string name, input logic [N-1:0] g, input int idx);
        @(negedge clk);
        cmp({name, "_grant"}, int'(grant), int'(g));
        cmp({name, "_valid"}, int'(grant_valid), int'(|g));
        cmp({name, "_idx"},   int'(grant_idx), idx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        request = '0;
`ifdef WRR_LOCK_EN
        lock    = '0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset and idle
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        cmp("rst_grant", int'(grant), 0);
        cmp("rst_valid", int'(grant_valid), 0);
        cmp("rst_idx",   int'(grant_idx), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) expect_cyc("idle", 4'b0000, 0);

        // Equal weights, request 1101
        do_reset();
        weight  = {4'd1, 4'd1, 4'd1, 4'd1};
        request = 4'b1101;
        for (int r = 0; r < 2; r++) begin
            expect_cyc("eq0", 4'b0001, 0);
            expect_cyc("eq2", 4'b0100, 2);
            expect_cyc("eq3", 4'b1000, 3);
        end

        // Weighted {1,2,1,3}, all requesting; then async reset mid-grant
        do_reset();
        weight  = {4'd1, 4'd2, 4'd1, 4'd3};
        request = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) expect_cyc("wt0", 4'b0001, 0);
            expect_cyc("wt1", 4'b0010, 1);
            for (int c = 0; c < 2; c++) expect_cyc("wt2", 4'b0100, 2);
            if (r == 0) expect_cyc("wt3", 4'b1000, 3);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_grant", int'(grant), 0);
        cmp("async_valid", int'(grant_valid), 0);
        cmp("async_idx",   int'(grant_idx), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Early release and wrap
        do_reset();
        weight  = {4'd4, 4'd4, 4'd4, 4'd4};
        request = 4'b0101;
        expect_cyc("er_a", 4'b0001, 0);
        expect_cyc("er_b", 4'b0001, 0);
        request = 4'b0100;
        expect_cyc("er_c", 4'b0100, 2);
        request = 4'b0010;
        expect_cyc("er_d", 4'b0010, 1);
        request = 4'b0000;
        expect_cyc("er_e", 4'b0000, 1);
        request = 4'b1111;
        expect_cyc("er_ptr", 4'b0100, 2);

        // Sole requester with weight 0
        do_reset();
        weight  = '0;
        request = 4'b0001;
        for (int i = 0; i < 10; i++) expect_cyc("sole", 4'b0001, 0);

`ifdef WRR_LOCK_EN
        // Lock holds past credit expiry
        do_reset();
        weight  = {4'd1, 4'd1, 4'd1, 4'd2};
        lock    = 4'b0001;
        request = 4'b0011;
        for (int i = 0; i < 6; i++) expect_cyc("lock0", 4'b0001, 0);
        lock = 4'b0000;
        expect_cyc("lock1", 4'b0010, 1);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) request = N'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) weight = (N*WGT_W)'($urandom);
`ifdef WRR_LOCK_EN
            if ($urandom_range(0, 3) == 0) lock = N'($urandom_range(0, 15));
`endif
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
- Parametrised N-requester weighted round-robin arbiter; successor to the fixed 4-way round-robin arbiter.
- Registered one-hot grant. Each winner holds the grant for up to its programmed weight in cycles, or until it drops its request. Priority then rotates past the last winner.
- Sits in front of shared resources (bus, memory port, FIFO write side) where requesters need unequal bandwidth shares.

Parameters:
- N, 4, number of requesters (2..16)
- WGT_W, 4, width of each per-requester weight field
- IDX_W, $clog2(N), width of grant_idx (derived; do not override)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- request  input  N  per-requester request, level, held until served
- weight  input  N*WGT_W  packed weights; requester i uses bits [i*WGT_W +: WGT_W]; sampled at grant issue
- grant  output  N  registered one-hot grant; all-zero when idle
- grant_valid  output  1  high when any grant bit is set
- grant_idx  output  IDX_W  binary index of current holder; holds last value when idle

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n=0 forces grant=0, grant_valid=0, grant_idx=0, ptr=0, credit=0, state=IDLE.
  - Reset asserted mid-grant drops the grant immediately (asynchronously).
  - First post-reset arbitration starts at requester 0.
- State: IDLE (no grant) or BUSY (one holder); ptr = highest-priority index for the next arbitration; credit = remaining cycles for the holder (WGT_W bits).
- Arbitration function: the winner is the first i with request[i]=1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around).
- Arbitrate at a clock edge when:
  - in IDLE, or
  - in BUSY with request[holder]=0, or
  - in BUSY with credit==1 (last granted cycle).
- On arbitration with a winner w:
  - grant <= one-hot(w); grant_idx <= w; state <= BUSY
  - credit <= weight[w], where weight 0 is treated as 1
  - ptr <= (w+1) mod N
- On arbitration with no requester: grant <= 0, state <= IDLE; ptr unchanged.
- In BUSY with no arbitration condition met: credit decrements by 1, grant holds.
- Latency: request arriving in IDLE produces a grant on the next rising edge (1 cycle).
- Handover: back-to-back, no bubble. The new grant appears on the same edge the old one ends.
- A holder that deasserts request in cycle t loses grant at edge t+1. Unused credit is discarded.
- A sole requester whose credit expires is re-granted immediately with fresh credit; grant stays high continuously.
- Simultaneous requests are resolved only by ptr order. A request rising in the same cycle as a handover is eligible.
- weight changes take effect only at the next grant issue for that requester.
- Outputs come directly from flops; no combinational path from request to grant.

Optional Feature:
- Macro: WRR_LOCK_EN.
- Defined:
  - Adds input port lock (width N).
  - While the holder has lock[holder]=1 and request[holder]=1, credit expiry is ignored and the grant holds; credit saturates at 1.
  - Deasserting lock with credit==1 releases at the next edge.
  - lock on non-holders is ignored.
- Undefined: no lock port; behaviour exactly as above.

Test Plan:
- Reset/idle: rst_n=0 for 15 ns, request=0 -> grant=0, grant_valid=0, grant_idx=0 throughout; no grant for 10 cycles after release.
- Equal weights: all weights=1, request=4'b1101 held -> grant sequence 0001,0100,1000,0001,... one cycle each, no gaps.
- Weighted: weights {w3,w2,w1,w0}={1,2,1,3}, request=4'b1111 -> requester 0 for 3 cycles, 1 for 1, 2 for 2, 3 for 1, then repeat; grant_idx matches each cycle.
- Early release and wrap: weights=4, request=4'b0101; requester 0 granted, drops request after 2 cycles -> grant moves to 0100 next edge. Then request=4'b0010 -> 0010. Then request=0 -> grant=0 next edge, ptr=2.
- Sole requester and weight 0: weight0=0, request=4'b0001 -> grant=0001 continuously, credit reloads to 1 every cycle; bench asserts no glitch cycle.
- Async reset mid-grant plus WRR_LOCK_EN: assert rst_n=0 between edges while BUSY -> grant=0 immediately. With macro defined, weight0=2, lock[0]=1 for 6 cycles, request=4'b0011 -> requester 0 holds 6 cycles; requester 1 is granted the edge after lock drops.
